// File: rtl/elevator_fsm.sv
// Eight-floor elevator car controller feeding a VGA display stage.
// Registers call requests, moves the car floor by floor with a travel
// timer, holds the door for a fixed time, and reports a target floor.
//
// state       | meaning
// ------------+--------------------------------------------------
// S_IDLE      | parked, no pending request
// S_UP        | travelling toward a higher floor
// S_DOWN      | travelling toward a lower floor
// S_DOOR      | door open at current_floor
module elevator_fsm #(
  parameter int FLOOR_CYCLES = 16,
  parameter int DOOR_CYCLES  = 32
) (
  input  logic       pixel_clk,
  input  logic       reset,
  input  logic [7:0] floor_req,
  output logic [7:0] destination,
  output logic [1:0] sim_state,
  output logic [2:0] current_floor,
  output logic [7:0] pending
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_UP   = 2'b01,
    S_DOWN = 2'b10,
    S_DOOR = 2'b11
  } state_t;

  localparam logic [15:0] FLOOR_LAST = 16'(FLOOR_CYCLES - 1);
  localparam logic [15:0] DOOR_LAST  = 16'(DOOR_CYCLES - 1);

  state_t      state_q, state_d;
  logic [2:0]  floor_q, floor_d;
  logic [7:0]  req_q, req_d;
  logic [15:0] timer_q, timer_d;
  logic        dir_up_q, dir_up_d;

  logic [7:0]  above_mask, below_mask;
  logic [7:0]  req_above, req_below;
  logic        pend_above, pend_below;
  logic [2:0]  floor_up, floor_dn;

  // Highest set bit of a vector, returned one-hot.
  function automatic logic [7:0] hi_bit(input logic [7:0] v);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) r = 8'd1 << i;
    end
    return r;
  endfunction

  assign above_mask = 8'hFE << floor_q;
  assign below_mask = ~(8'hFF << floor_q);
  assign req_above  = req_q & above_mask;
  assign req_below  = req_q & below_mask;
  assign pend_above = |req_above;
  assign pend_below = |req_below;
  assign floor_up   = floor_q + 3'd1;
  assign floor_dn   = floor_q - 3'd1;

  // State, position, request mask, timer and travel direction registers.
  always_ff @(posedge pixel_clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      floor_q  <= 3'd0;
      req_q    <= 8'h00;
      timer_q  <= 16'd0;
      dir_up_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      floor_q  <= floor_d;
      req_q    <= req_d;
      timer_q  <= timer_d;
      dir_up_q <= dir_up_d;
    end
  end

  // Next-state, request bookkeeping and timer control.
  always_comb begin
    state_d  = state_q;
    floor_d  = floor_q;
    timer_d  = timer_q;
    dir_up_d = dir_up_q;
    req_d    = req_q | floor_req;

    case (state_q)
      S_IDLE: begin
        timer_d = 16'd0;
        if (req_q[floor_q]) begin
          state_d        = S_DOOR;
          req_d[floor_q] = 1'b0;
        end else if (pend_above) begin
          state_d  = S_UP;
          dir_up_d = 1'b1;
        end else if (pend_below) begin
          state_d  = S_DOWN;
          dir_up_d = 1'b0;
        end
      end

      S_UP, S_DOWN: begin
        if (timer_q == FLOOR_LAST) begin
          timer_d = 16'd0;
          if (state_q == S_UP && floor_q != 3'd7) begin
            floor_d = floor_up;
            if (req_q[floor_up]) begin
              state_d         = S_DOOR;
              req_d[floor_up] = 1'b0;
            end
          end else if (state_q == S_DOWN && floor_q != 3'd0) begin
            floor_d = floor_dn;
            if (req_q[floor_dn]) begin
              state_d         = S_DOOR;
              req_d[floor_dn] = 1'b0;
            end
          end else begin
            // Unreachable with consistent requests; park rather than wrap.
            state_d = S_IDLE;
          end
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end

      S_DOOR: begin
        // A call for the floor we are already serving only extends the door.
        req_d[floor_q] = req_q[floor_q];
        if (floor_req[floor_q]) begin
          timer_d = 16'd0;
        end else if (timer_q == DOOR_LAST) begin
          timer_d = 16'd0;
          if (dir_up_q && pend_above) begin
            state_d = S_UP;
          end else if (!dir_up_q && pend_below) begin
            state_d = S_DOWN;
          end else if (pend_above) begin
            state_d  = S_UP;
            dir_up_d = 1'b1;
          end else if (pend_below) begin
            state_d  = S_DOWN;
            dir_up_d = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Display-facing target floor, derived from registered state only.
  always_comb begin
    destination = 8'h00;
    case (state_q)
      S_UP:    destination = req_above & (~req_above + 8'd1);
      S_DOWN:  destination = hi_bit(req_below);
      S_DOOR:  destination = 8'd1 << floor_q;
      default: destination = 8'h00;
    endcase
  end

  assign sim_state     = state_q;
  assign current_floor = floor_q;
  assign pending       = req_q;

endmodule

// File: tb/tb_elevator_fsm.sv
// Self-checking bench for elevator_fsm: directed scenarios plus randomized
// call traffic, all compared against a behavioural car model.
module tb_elevator_fsm;

  localparam int FC = 4;
  localparam int DC = 8;

  localparam int M_IDLE = 0;
  localparam int M_UP   = 1;
  localparam int M_DOWN = 2;
  localparam int M_DOOR = 3;

  logic       pixel_clk;
  logic       reset;
  logic [7:0] floor_req;
  logic [7:0] destination;
  logic [1:0] sim_state;
  logic [2:0] current_floor;
  logic [7:0] pending;

  int n_checks;
  int n_errors;

  // Behavioural model: car mode, floor, elapsed cycles in the current
  // activity, last travel direction and the set of outstanding calls.
  int m_mode;
  int m_floor;
  int m_elapsed;
  bit m_dir_up;
  bit m_pend[8];

  elevator_fsm #(.FLOOR_CYCLES(FC), .DOOR_CYCLES(DC)) dut (
    .pixel_clk     (pixel_clk),
    .reset         (reset),
    .floor_req     (floor_req),
    .destination   (destination),
    .sim_state     (sim_state),
    .current_floor (current_floor),
    .pending       (pending)
  );

  initial pixel_clk = 1'b0;
  always #5 pixel_clk = ~pixel_clk;

  initial begin
    #3000000;
    $display("FAIL timeout: run exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit any_calls(input bit p[8], input int f, input bit up);
    bit r = 0;
    for (int i = 0; i < 8; i++) begin
      if (p[i] && ((up && i > f) || (!up && i < f))) r = 1;
    end
    return r;
  endfunction

  function automatic logic [7:0] m_pend_vec();
    logic [7:0] v = '0;
    for (int i = 0; i < 8; i++) v[i] = m_pend[i];
    return v;
  endfunction

  function automatic logic [7:0] m_target();
    logic [7:0] t = '0;
    if (m_mode == M_UP) begin
      for (int i = 7; i > m_floor; i--) if (m_pend[i]) t = 8'h00 | (8'd1 << i);
    end else if (m_mode == M_DOWN) begin
      for (int i = 0; i < m_floor; i++) if (m_pend[i]) t = 8'd1 << i;
    end else if (m_mode == M_DOOR) begin
      t = 8'd1 << m_floor;
    end
    return t;
  endfunction

  task automatic m_reset();
    m_mode    = M_IDLE;
    m_floor   = 0;
    m_elapsed = 0;
    m_dir_up  = 1;
    for (int i = 0; i < 8; i++) m_pend[i] = 0;
  endtask

  // Advance the model across one clock edge with calls fr present.
  task automatic m_step(input logic [7:0] fr);
    bit old[8];
    bit served[8];
    bit held[8];
    int f;
    f = m_floor;
    for (int i = 0; i < 8; i++) begin
      old[i] = m_pend[i];
      served[i] = 0;
      held[i] = 0;
    end
    case (m_mode)
      M_IDLE: begin
        if (old[f]) begin
          m_mode = M_DOOR; m_elapsed = 0; served[f] = 1;
        end else if (any_calls(old, f, 1)) begin
          m_mode = M_UP; m_elapsed = 0; m_dir_up = 1;
        end else if (any_calls(old, f, 0)) begin
          m_mode = M_DOWN; m_elapsed = 0; m_dir_up = 0;
        end
      end
      M_UP, M_DOWN: begin
        m_elapsed++;
        if (m_elapsed == FC) begin
          m_elapsed = 0;
          m_floor = (m_mode == M_UP) ? f + 1 : f - 1;
          if (old[m_floor]) begin
            m_mode = M_DOOR; served[m_floor] = 1;
          end
        end
      end
      default: begin
        held[f] = 1;
        if (fr[f]) begin
          m_elapsed = 0;
        end else begin
          m_elapsed++;
          if (m_elapsed == DC) begin
            m_elapsed = 0;
            if (any_calls(old, f, m_dir_up)) begin
              m_mode = m_dir_up ? M_UP : M_DOWN;
            end else if (any_calls(old, f, !m_dir_up)) begin
              m_dir_up = !m_dir_up;
              m_mode = m_dir_up ? M_UP : M_DOWN;
            end else begin
              m_mode = M_IDLE;
            end
          end
        end
      end
    endcase
    for (int i = 0; i < 8; i++) begin
      if (served[i]) m_pend[i] = 0;
      else if (held[i]) m_pend[i] = old[i];
      else m_pend[i] = old[i] | fr[i];
    end
  endtask

  task automatic compare_model();
    check_eq("sim_state", 32'(sim_state), 32'(m_mode));
    check_eq("current_floor", 32'(current_floor), 32'(m_floor));
    check_eq("pending", 32'(pending), 32'(m_pend_vec()));
    check_eq("destination", 32'(destination), 32'(m_target()));
  endtask

  // Called at a falling edge: drive calls, cross one rising edge, compare.
  task automatic cycle(input logic [7:0] fr);
    floor_req = fr;
    m_step(fr);
    @(posedge pixel_clk);
    @(negedge pixel_clk);
    compare_model();
  endtask

  task automatic run_idle(input int n);
    for (int i = 0; i < n; i++) cycle(8'h00);
  endtask

  // Called at a falling edge: pulse reset between edges and check that
  // outputs clear before any clock edge arrives.
  task automatic do_reset();
    floor_req = 8'h00;
    #2;
    reset = 1'b0;
    #1;
    check_eq("rst_state", 32'(sim_state), 32'd0);
    check_eq("rst_floor", 32'(current_floor), 32'd0);
    check_eq("rst_dest", 32'(destination), 32'h00);
    check_eq("rst_pending", 32'(pending), 32'h00);
    m_reset();
    @(negedge pixel_clk);
    reset = 1'b1;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    floor_req = 8'h00;
    reset     = 1'b0;
    m_reset();
    #3;
    check_eq("init_state", 32'(sim_state), 32'd0);
    check_eq("init_dest", 32'(destination), 32'h00);
    check_eq("init_pending", 32'(pending), 32'h00);
    @(negedge pixel_clk);
    reset = 1'b1;

    // Single call to floor 3 from floor 0.
    cycle(8'h08);
    check_eq("t1_pending", 32'(pending), 32'h08);
    cycle(8'h00);
    check_eq("t1_state_up", 32'(sim_state), 32'd1);
    check_eq("t1_dest", 32'(destination), 32'h08);
    run_idle(11);
    check_eq("t1_still_moving", 32'(sim_state), 32'd1);
    cycle(8'h00);
    check_eq("t1_floor", 32'(current_floor), 32'd3);
    check_eq("t1_door", 32'(sim_state), 32'd3);
    check_eq("t1_cleared", 32'(pending), 32'h00);
    run_idle(7);
    check_eq("t1_door_held", 32'(sim_state), 32'd3);
    cycle(8'h00);
    check_eq("t1_idle", 32'(sim_state), 32'd0);

    // Go down to floor 2, then a call at the parked floor and a door re-pulse.
    cycle(8'h04);
    cycle(8'h00);
    check_eq("t2_down", 32'(sim_state), 32'd2);
    run_idle(4);
    check_eq("t2_floor2", 32'(current_floor), 32'd2);
    run_idle(8);
    check_eq("t2_idle", 32'(sim_state), 32'd0);
    cycle(8'h04);
    check_eq("t2_pend", 32'(pending), 32'h04);
    cycle(8'h00);
    check_eq("t2_door", 32'(sim_state), 32'd3);
    check_eq("t2_no_move", 32'(current_floor), 32'd2);
    check_eq("t2_pend_clr", 32'(pending), 32'h00);
    run_idle(4);
    cycle(8'h04);
    check_eq("t2_repulse_pend", 32'(pending), 32'h00);
    run_idle(7);
    check_eq("t2_door_extended", 32'(sim_state), 32'd3);
    cycle(8'h00);
    check_eq("t2_idle_after", 32'(sim_state), 32'd0);

    // Mid-travel call between car and target becomes the new stop.
    do_reset();
    cycle(8'h20);
    cycle(8'h00);
    check_eq("t3_dest5", 32'(destination), 32'h20);
    run_idle(4);
    check_eq("t3_floor1", 32'(current_floor), 32'd1);
    cycle(8'h04);
    check_eq("t3_dest2", 32'(destination), 32'h04);
    run_idle(3);
    check_eq("t3_stop2", 32'(current_floor), 32'd2);
    check_eq("t3_door2", 32'(sim_state), 32'd3);
    check_eq("t3_pend", 32'(pending), 32'h20);
    run_idle(8);
    check_eq("t3_resume", 32'(sim_state), 32'd1);
    run_idle(12);
    check_eq("t3_floor5", 32'(current_floor), 32'd5);
    check_eq("t3_door5", 32'(sim_state), 32'd3);

    // Door at floor 4 heading up with calls at 7 and 0.
    do_reset();
    cycle(8'h10);
    cycle(8'h00);
    run_idle(16);
    check_eq("t4_floor4", 32'(current_floor), 32'd4);
    check_eq("t4_door4", 32'(sim_state), 32'd3);
    cycle(8'h81);
    run_idle(6);
    check_eq("t4_door_hold", 32'(sim_state), 32'd3);
    cycle(8'h00);
    check_eq("t4_up", 32'(sim_state), 32'd1);
    check_eq("t4_dest7", 32'(destination), 32'h80);
    run_idle(12);
    check_eq("t4_floor7", 32'(current_floor), 32'd7);
    run_idle(8);
    check_eq("t4_down", 32'(sim_state), 32'd2);
    check_eq("t4_dest0", 32'(destination), 32'h01);
    run_idle(28);
    check_eq("t4_floor0", 32'(current_floor), 32'd0);
    check_eq("t4_door0", 32'(sim_state), 32'd3);

    // Reset while travelling between floors 3 and 4.
    do_reset();
    cycle(8'h80);
    cycle(8'h00);
    run_idle(14);
    check_eq("t5_floor3", 32'(current_floor), 32'd3);
    check_eq("t5_moving", 32'(sim_state), 32'd1);
    do_reset();
    cycle(8'h00);

    // Randomized call traffic with occasional resets.
    for (int n = 0; n < 4000; n++) begin
      int r;
      logic [7:0] fr;
      r = int'($urandom_range(0, 11));
      if (r == 0) fr = 8'd1 << $urandom_range(0, 7);
      else if (r == 1) fr = 8'($urandom);
      else fr = 8'h00;
      cycle(fr);
      if ($urandom_range(0, 599) == 0) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
